// File: rtl/am_modulator.sv
`timescale 1ns/1ps
// am_modulator: amplitude-modulates the NCO carrier with a held, depth-scaled audio
// sample, then applies a click-free mute/unmute gain ramp to produce the DAC word.
module am_modulator #(
  parameter int AUD_W     = 16,
  parameter int RAMP_LOG2 = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [13:0]      carrier,
  input  logic signed [AUD_W-1:0] audio_data,
  input  logic                    audio_valid,
  output logic                    audio_ready,
  input  logic [7:0]              mod_depth,
  input  logic                    enable,
  output logic signed [13:0]      dac_out,
  output logic                    out_valid,
  output logic                    muted
);
  localparam int            PW        = (RAMP_LOG2 > 0) ? RAMP_LOG2 : 1;
  localparam logic [PW-1:0] PMAX      = PW'((1 << RAMP_LOG2) - 1);
  localparam logic [8:0]    GAIN_FULL = 9'd256;

  typedef enum logic [1:0] {S_MUTE, S_UP, S_ON, S_DOWN} state_t;

  function automatic logic signed [13:0] sat_s14(input logic signed [29:0] x);
    if (x > 30'sd8191)       return {1'b0, {13{1'b1}}};
    else if (x < -30'sd8192) return {1'b1, 13'd0};
    else                     return x[13:0];
  endfunction

  // Envelope 2^23 + d*a never goes negative, so its top 15 bits are an unsigned scale.
  function automatic logic [14:0] envelope(input logic signed [AUD_W-1:0] a,
                                           input logic [7:0] d);
    logic signed [23:0] p;
    p = 24'(a) * $signed({16'd0, d});
    return 15'((24'h800000 + p) >> 9);
  endfunction

  function automatic logic signed [13:0] mix(input logic signed [13:0] c,
                                             input logic [14:0] e);
    logic signed [29:0] prod;
    prod = 30'(c) * $signed({15'd0, e});
    return sat_s14(prod >>> 15);
  endfunction

  function automatic logic signed [13:0] apply_gain(input logic signed [13:0] s,
                                                    input logic [8:0] g);
    logic signed [29:0] prod;
    prod = 30'(s) * $signed({21'd0, g});
    return sat_s14(prod >>> 8);
  endfunction

  state_t                  r_state, w_state_nxt;
  logic [8:0]              r_gain, w_gain_nxt;
  logic [PW-1:0]           r_presc, w_presc_nxt;
  logic                    w_step, w_muted_nxt, r_muted;
  logic                    r_ready, w_xfer;
  logic signed [AUD_W-1:0] r_aud;
  logic [7:0]              r_depth;
  logic signed [13:0]      r_car_p1, r_s_p2, r_dac_p3;
  logic [14:0]             r_e_p1;
  logic                    r_vld_p1, r_vld_p2, r_vld_p3;

  assign w_xfer = audio_valid && r_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready  <= 1'b0;
      r_aud    <= '0;
      r_depth  <= '0;
      r_car_p1 <= '0;
      r_e_p1   <= '0;
      r_vld_p1 <= 1'b0;
      r_s_p2   <= '0;
      r_vld_p2 <= 1'b0;
      r_dac_p3 <= '0;
      r_vld_p3 <= 1'b0;
    end else begin
      r_ready <= 1'b1;
      if (w_xfer) begin
        r_aud   <= audio_data;
        r_depth <= mod_depth;
      end
      // Stage 1: carrier and envelope scale
      r_car_p1 <= carrier;
      r_e_p1   <= envelope(r_aud, r_depth);
      r_vld_p1 <= 1'b1;
      // Stage 2: modulated carrier
      r_s_p2   <= mix(r_car_p1, r_e_p1);
      r_vld_p2 <= r_vld_p1;
      // Stage 3: gain ramp applied with the gain current at this stage
      r_dac_p3 <= apply_gain(r_s_p2, r_gain);
      r_vld_p3 <= r_vld_p2;
    end
  end

  assign w_step = (r_presc == PMAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_MUTE;
      r_gain  <= '0;
      r_presc <= '0;
      r_muted <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_gain  <= w_gain_nxt;
      r_presc <= w_presc_nxt;
      r_muted <= w_muted_nxt;
    end
  end

  // A step always follows the current direction; enable only redirects the next one.
  always_comb begin
    w_state_nxt = r_state;
    w_gain_nxt  = r_gain;
    w_presc_nxt = w_step ? '0 : r_presc + PW'(1);
    case (r_state)
      S_MUTE: begin
        w_gain_nxt  = '0;
        w_presc_nxt = '0;
        if (enable) w_state_nxt = S_UP;
      end
      S_UP: begin
        if (w_step) begin
          if (r_gain >= GAIN_FULL - 9'd1) begin
            w_gain_nxt  = GAIN_FULL;
            w_state_nxt = S_ON;
          end else begin
            w_gain_nxt = r_gain + 9'd1;
          end
        end
        if (!enable) w_state_nxt = S_DOWN;
      end
      S_ON: begin
        w_gain_nxt  = GAIN_FULL;
        w_presc_nxt = '0;
        if (!enable) w_state_nxt = S_DOWN;
      end
      S_DOWN: begin
        if (w_step) begin
          if (r_gain <= 9'd1) begin
            w_gain_nxt  = '0;
            w_state_nxt = S_MUTE;
          end else begin
            w_gain_nxt = r_gain - 9'd1;
          end
        end
        if (enable) w_state_nxt = S_UP;
      end
      default: w_state_nxt = S_MUTE;
    endcase
  end

  always_comb begin
    w_muted_nxt = (w_state_nxt == S_MUTE);
  end

  assign audio_ready = r_ready;
  assign dac_out     = r_dac_p3;
  assign out_valid   = r_vld_p3;
  assign muted       = r_muted;

endmodule

// File: tb/tb_am_modulator.sv
`timescale 1ns/1ps
// Directed bench for am_modulator (RAMP_LOG2=0 so the gain steps every cycle):
// reset, gain ramps, modulation vectors, handshake latency and streaming.
module tb_am_modulator;
  logic               clk = 1'b0;
  logic               rst;
  logic signed [13:0] carrier;
  logic signed [15:0] audio_data;
  logic               audio_valid;
  logic               audio_ready;
  logic [7:0]         mod_depth;
  logic               enable;
  logic signed [13:0] dac_out;
  logic               out_valid;
  logic               muted;

  int checks = 0;
  int errors = 0;
  int g_prev = 0;

  typedef struct {
    int car;
    int aud;
    int dep;
    int exp;
  } vec_t;

  vec_t vt[9];
  int   sa[5];
  int   se[5];

  always #4 clk = ~clk;

  am_modulator #(.AUD_W(16), .RAMP_LOG2(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .carrier    (carrier),
    .audio_data (audio_data),
    .audio_valid(audio_valid),
    .audio_ready(audio_ready),
    .mod_depth  (mod_depth),
    .enable     (enable),
    .dac_out    (dac_out),
    .out_valid  (out_valid),
    .muted      (muted)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Unmodulated carrier 4000 gives s = 2000; dac = (2000*gain) >>> 8.
  function automatic int fg(input int g);
    return (2000 * g) >>> 8;
  endfunction

  // Drive enable, clock once, check dac against the gain held before this edge.
  task automatic tick_gain(input logic en, input int g_new, input string name);
    enable = en;
    step();
    chk(name, int'(dac_out), fg(g_prev));
    g_prev = g_new;
  endtask

  initial begin
    vt[0] = '{car:  8191, aud:  32767, dep: 255, exp:  8174};
    vt[1] = '{car:  8191, aud: -32768, dep: 255, exp:    15};
    vt[2] = '{car: -8192, aud:  12345, dep:   0, exp: -4096};
    vt[3] = '{car:  4000, aud:      0, dep:   0, exp:  2000};
    vt[4] = '{car: -8192, aud:  32767, dep: 255, exp: -8176};
    vt[5] = '{car:  1000, aud:  16384, dep: 128, exp:   625};
    vt[6] = '{car:    -1, aud:      0, dep:   0, exp:    -1};
    vt[7] = '{car:  8191, aud:      0, dep:   0, exp:  4095};
    vt[8] = '{car:    -3, aud: -16384, dep:  64, exp:    -2};
    sa = '{0, 32767, -32768, 16384, -16384};
    se = '{4095, 8174, 15, 6135, 2055};

    rst = 1'b1; enable = 1'b0; carrier = 14'sd4000;
    audio_data = '0; audio_valid = 1'b0; mod_depth = '0;

    // Power-on reset and release timing
    step(); step();
    chk("rst_dac", int'(dac_out), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_ready", int'(audio_ready), 0);
    chk("rst_muted", int'(muted), 1);
    rst = 1'b0;
    step();
    chk("rel1_out_valid", int'(out_valid), 0);
    chk("rel1_ready", int'(audio_ready), 1);
    step();
    chk("rel2_out_valid", int'(out_valid), 0);
    step();
    chk("rel3_out_valid", int'(out_valid), 1);
    step(); step();
    chk("mute_dac", int'(dac_out), 0);

    // Pass 1: rise to 100, then fall all the way to MUTE
    g_prev = 0;
    tick_gain(1'b1, 0, "p1_start");
    chk("p1_unmuted", int'(muted), 0);
    for (int k = 1; k <= 99; k++) tick_gain(1'b1, k, "p1_rise");
    tick_gain(1'b0, 100, "p1_peak");
    for (int k = 101; k <= 199; k++) tick_gain(1'b0, 200 - k, "p1_fall");
    chk("p1_not_muted_yet", int'(muted), 0);
    tick_gain(1'b0, 0, "p1_zero");
    chk("p1_muted", int'(muted), 1);
    tick_gain(1'b0, 0, "p1_silent");
    tick_gain(1'b0, 0, "p1_silent");

    // Pass 2: rise to 100, fall to 50, re-enable and ramp fully on
    tick_gain(1'b1, 0, "p2_start");
    for (int k = 1; k <= 99; k++) tick_gain(1'b1, k, "p2_rise");
    tick_gain(1'b0, 100, "p2_peak");
    for (int k = 101; k <= 149; k++) tick_gain(1'b0, 200 - k, "p2_fall");
    tick_gain(1'b1, 50, "p2_turn");
    for (int k = 151; k <= 356; k++) tick_gain(1'b1, k - 100, "p2_rerise");
    for (int k = 0; k < 4; k++) tick_gain(1'b1, 256, "p2_on");
    chk("on_full_scale", int'(dac_out), 2000);
    chk("on_muted", int'(muted), 0);

    // Modulation vectors at full gain
    for (int i = 0; i < 9; i++) begin
      carrier = 14'(vt[i].car);
      audio_data = 16'(vt[i].aud);
      mod_depth = 8'(vt[i].dep);
      audio_valid = 1'b1;
      step();
      audio_valid = 1'b0;
      step(); step(); step();
      chk($sformatf("vec%0d", i), int'(dac_out), vt[i].exp);
    end

    // Depth change without a transfer is ignored; a transfer shows 4 edges later
    carrier = 14'sd8191; audio_data = 16'sd32767; mod_depth = 8'd0;
    audio_valid = 1'b1;
    step();
    audio_valid = 1'b0;
    step(); step(); step();
    chk("dep_base", int'(dac_out), 4095);
    mod_depth = 8'd255; audio_data = -16'sd5;
    for (int k = 0; k < 6; k++) step();
    chk("dep_no_xfer", int'(dac_out), 4095);
    audio_data = 16'sd32767; audio_valid = 1'b1;
    step();
    audio_valid = 1'b0;
    step(); step();
    chk("dep_latency_early", int'(dac_out), 4095);
    step();
    chk("dep_latency", int'(dac_out), 8174);

    // Back-to-back audio transfers
    for (int k = 0; k < 8; k++) begin
      if (k < 5) begin
        audio_valid = 1'b1;
        audio_data = 16'(sa[k]);
      end else begin
        audio_valid = 1'b0;
      end
      step();
      if (k < 5) chk("stream_ready", int'(audio_ready), 1);
      if (k >= 3) chk($sformatf("stream%0d", k - 3), int'(dac_out), se[k - 3]);
      else        chk("stream_hold", int'(dac_out), 8174);
    end

    // Reset from ON, then reset again mid-ramp at gain 100
    rst = 1'b1; enable = 1'b0; audio_valid = 1'b0;
    step();
    chk("rst2_dac", int'(dac_out), 0);
    chk("rst2_muted", int'(muted), 1);
    rst = 1'b0; carrier = 14'sd4000;
    for (int k = 0; k < 4; k++) step();
    enable = 1'b1;
    step();
    for (int k = 0; k < 100; k++) step();
    chk("pre_rst_dac", int'(dac_out), fg(99));
    rst = 1'b1;
    step();
    chk("midrst_dac", int'(dac_out), 0);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_ready", int'(audio_ready), 0);
    chk("midrst_muted", int'(muted), 1);
    rst = 1'b0; enable = 1'b0;
    step();
    chk("midrel1_out_valid", int'(out_valid), 0);
    chk("midrel1_ready", int'(audio_ready), 1);
    step();
    chk("midrel2_out_valid", int'(out_valid), 0);
    step();
    chk("midrel3_out_valid", int'(out_valid), 1);
    for (int k = 0; k < 5; k++) step();
    chk("midrel_gain_zero", int'(dac_out), 0);
    chk("midrel_muted", int'(muted), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
